pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline hazard/redirect controller for the in-order core: collects per-stage stall requests, branch redirects and commit-stage exception/return events, and drives per-stage stall and flush vectors plus the registered PC redirect to the fetch unit. It is the generalised successor of the fixed 5-stage controller. Stage count, branch-resolve stage and fetch-shadow length are all parameters. It adds per-stage stall bubbles, an exception-return path and optional performance counters.

## Interface
Parameters:
- `STAGES`, default 5: pipeline stages; index 0 is fetch, `STAGES-1` is commit. Range 3..8.
- `BR_STAGE`, default 2: stage that resolves branches. Range 1..`STAGES-2`.
- `FLUSH_CYCLES`, default 1: fetch-shadow cycles killed after a redirect. Range 0..7.
- `ADDR_W`, default 32: PC width.

Ports:
- `clk`  in  1  the single clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `stallreq_i`  in  `STAGES`  per-stage stall request.
- `branch_redirect_i`  in  1  taken/mispredicted branch resolved in `BR_STAGE`.
- `branch_target_i`  in  `ADDR_W`  branch target.
- `exc_valid_i`  in  1  exception at commit.
- `eentry_i`  in  `ADDR_W`  exception entry address.
- `ertn_i`  in  1  exception return at commit.
- `era_i`  in  `ADDR_W`  return address.
- `stall_o`  out  `STAGES`  hold stage register.
- `flush_o`  out  `STAGES`  invalidate stage register (bubble).
- `redirect_o`  out  1  one-cycle PC redirect strobe.
- `new_pc_o`  out  `ADDR_W`  redirect target, valid when `redirect_o` is high.
- `stall_cnt_o`  out  32  stall-cycle counter.
- `redirect_cnt_o`  out  32  redirect-event counter.

## Operation
- Event priority, highest first: `exc_valid_i`, then `ertn_i`, then accepted branch, then stall.
- **Stall**: let k be the highest index with `stallreq_i[k]=1`.
  - `stall_o[j]=1` for all j≤k.
  - If k<`STAGES-1`, `flush_o[k+1]=1`, which inserts a bubble downstream.
  - All of this is combinational.
- **Branch**: accepted only when `branch_redirect_i=1`, `stall_o[BR_STAGE]=0`, and there is no exception or ertn.
  - In the same cycle, `flush_o[j]=1` for j<`BR_STAGE` and `stall_o` is forced to 0 for those stages.
  - The shadow counter loads `FLUSH_CYCLES`.
- **Exception/ertn**:
  - In the same cycle, `flush_o` is all ones and `stall_o` is all zeros.
  - The shadow counter loads `FLUSH_CYCLES`.
  - Target: `eentry_i` for an exception, `era_i` for ertn.
- **Redirect register**: the target is captured at the event edge. `redirect_o=1` for exactly one cycle after the event.
- **Shadow counter** (3 bits):
  - While it is nonzero, `flush_o[0]=1`.
  - It decrements only when `stall_o[0]=0`. If stage 0 is stalled, it holds and `flush_o[0]` stays high.
  - A new accepted event reloads it; the latest event wins.
- State machine:
  - IDLE: counter=0, no redirect pending.
  - REDIRECT: the cycle with `redirect_o` high.
  - SHADOW: counter>0.
  - REDIRECT and SHADOW may coincide.
  - With `FLUSH_CYCLES=0` there is no SHADOW state.

## Timing
- **Reset values**:
  - `stall_o` = 0, `flush_o` = 0, `redirect_o` = 0, `new_pc_o` = 0.
  - Shadow counter = 0; both count outputs = 0.
  - While `rst=1`, the combinational outputs are forced to 0.
- **Latency**:
  - stall/flush outputs: 0 cycles from inputs.
  - `redirect_o`/`new_pc_o`: 1 cycle.
- For an event at cycle T:
  - `redirect_o` is high at T+1.
  - `flush_o[0]` is high at T+1..T+`FLUSH_CYCLES`, assuming no stage-0 stall.
- **Simultaneous events**:
  - Exception plus branch, or exception plus ertn: the exception wins and the other event is dropped.
  - Branch plus a stall at stage ≥`BR_STAGE`: the branch is not accepted and must be re-presented.
  - Branch or exception during SHADOW or REDIRECT: accepted, and the target and counter are reloaded.
- **Reset mid-SHADOW**: the counter clears and `redirect_o` is 0 from the next cycle.

## Configuration
- `PIPE_CTRL_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments each cycle with `stall_o[0]=1`.
  - `redirect_cnt_o` increments each cycle with `redirect_o=1`.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by `rst`.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- **Stall**: defaults, `stallreq_i=5'b00100` -> `stall_o=5'b00111`, `flush_o=5'b01000`, `redirect_o=0`.
- **Branch**:
  - Stimulus: `branch_redirect_i=1`, target 0x1C000040, at T.
  - At T: `flush_o=5'b00011`.
  - At T+1: `redirect_o=1`, `new_pc_o=0x1C000040`, `flush_o[0]=1`.
  - At T+2: `flush_o[0]=0`.
- **Exception vs. branch**:
  - Stimulus: `exc_valid_i=1` and `branch_redirect_i=1` at T, `eentry_i=0x1C008000`.
  - At T: `flush_o=5'b11111`.
  - At T+1: `new_pc_o=0x1C008000`.
- **ertn**: `ertn_i=1`, `era_i=0x1C000104` -> `redirect_o` at T+1 with `new_pc_o=0x1C000104`.
- **Blocked branch, then shadow freeze** (`FLUSH_CYCLES=2`):
  - `stallreq_i[3]=1` with a branch at T -> branch ignored and `redirect_o=0` at T+1.
  - Re-present the branch at T+2 with no stall, then hold `stallreq_i[0]=1` for 3 cycles from T+3.
  - Required: `flush_o[0]` stays high through the stall and for 2 further unstalled cycles.
- **Counters and reset** (macro defined):
  - 4 stall cycles plus 1 branch -> `stall_cnt_o=4`, `redirect_cnt_o=1`.
  - `rst` in SHADOW -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-stage stall/flush vectors and registered PC redirect.
// Optional performance counters are built only when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned STAGES       = 5,
    parameter int unsigned BR_STAGE     = 2,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic              branch_redirect_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              exc_valid_i,
    input  logic [ADDR_W-1:0] eentry_i,
    input  logic              ertn_i,
    input  logic [ADDR_W-1:0] era_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] new_pc_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       redirect_cnt_o
);

    if (STAGES < 3 || STAGES > 8 || BR_STAGE < 1 || BR_STAGE > STAGES - 2 ||
        FLUSH_CYCLES > 7) begin : g_param_check
        $error("pipe_ctrl: parameter out of range");
    end

    localparam logic [STAGES-1:0] BrMask    = STAGES'((1 << BR_STAGE) - 1);
    localparam logic [2:0]        FlushInit = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {StIdle, StRedirect, StShadow} state_e;

    state_e            state_q;
    logic [2:0]        shadow_q;
    logic [2:0]        shadow_step;
    logic [ADDR_W-1:0] new_pc_q;
    logic [ADDR_W-1:0] target;
    logic [STAGES-1:0] stall_base;
    logic [STAGES-1:0] flush_base;
    logic              exc_evt;
    logic              ertn_evt;
    logic              br_acc;
    logic              redir_evt;

    // stall_base[j] is set when any stage at or above j requests a stall; the bubble
    // goes into the stage just above the highest requester.
    always_comb begin
        stall_base[STAGES-1] = stallreq_i[STAGES-1];
        for (int j = STAGES - 2; j >= 0; j--) begin
            stall_base[j] = stall_base[j+1] | stallreq_i[j];
        end
        flush_base[0] = 1'b0;
        for (int j = 1; j < STAGES; j++) begin
            flush_base[j] = stall_base[j-1] & ~stall_base[j];
        end
    end

    always_comb begin
        exc_evt   = exc_valid_i;
        ertn_evt  = ertn_i & ~exc_valid_i;
        br_acc    = branch_redirect_i & ~stall_base[BR_STAGE] & ~exc_valid_i & ~ertn_i;
        redir_evt = exc_evt | ertn_evt | br_acc;
        if (exc_evt) begin
            target = eentry_i;
        end else if (ertn_evt) begin
            target = era_i;
        end else begin
            target = branch_target_i;
        end
    end

    always_comb begin
        stall_o = '0;
        flush_o = '0;
        if (!rst) begin
            stall_o = stall_base;
            flush_o = flush_base;
            if (exc_evt || ertn_evt) begin
                stall_o = '0;
                flush_o = '1;
            end else if (br_acc) begin
                stall_o = stall_base & ~BrMask;
                flush_o = flush_base | BrMask;
            end
            if (shadow_q != 3'd0) begin
                flush_o[0] = 1'b1;
            end
        end
    end

    // The fetch shadow only drains while fetch is actually advancing.
    always_comb begin
        shadow_step = shadow_q;
        if (shadow_q != 3'd0 && !stall_o[0]) begin
            shadow_step = shadow_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= 3'd0;
            new_pc_q <= '0;
        end else if (redir_evt) begin
            state_q  <= StRedirect;
            shadow_q <= FlushInit;
            new_pc_q <= target;
        end else begin
            shadow_q <= shadow_step;
            state_q  <= (shadow_step != 3'd0) ? StShadow : StIdle;
        end
    end

    assign redirect_o = (state_q == StRedirect);
    assign new_pc_o   = new_pc_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (stall_o[0] && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_o && redirect_cnt_q != 32'hFFFF_FFFF) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`else
    assign stall_cnt_o    = 32'd0;
    assign redirect_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_CYCLES 1 and 2) against a behavioural model,
// directed literal checks, then randomized traffic.
module tb_pipe_ctrl;
    localparam int S  = 5;
    localparam int AW = 32;
    localparam int BR = 2;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [S-1:0]  stallreq;
    logic          br;
    logic [AW-1:0] br_tgt;
    logic          exc;
    logic [AW-1:0] eentry;
    logic          ertn;
    logic [AW-1:0] era;

    logic [S-1:0]  stall_w [2];
    logic [S-1:0]  flush_w [2];
    logic          redir_w [2];
    logic [AW-1:0] pc_w    [2];
    logic [31:0]   scnt_w  [2];
    logic [31:0]   rcnt_w  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_ctrl #(
            .STAGES      (S),
            .BR_STAGE    (BR),
            .FLUSH_CYCLES(g + 1),
            .ADDR_W      (AW)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .stallreq_i       (stallreq),
            .branch_redirect_i(br),
            .branch_target_i  (br_tgt),
            .exc_valid_i      (exc),
            .eentry_i         (eentry),
            .ertn_i           (ertn),
            .era_i            (era),
            .stall_o          (stall_w[g]),
            .flush_o          (flush_w[g]),
            .redirect_o       (redir_w[g]),
            .new_pc_o         (pc_w[g]),
            .stall_cnt_o      (scnt_w[g]),
            .redirect_cnt_o   (rcnt_w[g])
        );
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model state per instance
    int          m_cnt   [2];
    bit          m_redir [2];
    logic [31:0] m_pc    [2];
    logic [31:0] m_scnt  [2];
    logic [31:0] m_rcnt  [2];
    bit          model_valid = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int           k;
            logic [S-1:0] es;
            logic [S-1:0] ef;
            bit           evt;
            logic [31:0]  tgt;
            k   = -1;
            es  = '0;
            ef  = '0;
            evt = 1'b0;
            tgt = '0;
            for (int j = 0; j < S; j++) if (stallreq[j]) k = j;
            if (!rst) begin
                for (int j = 0; j <= k; j++) es[j] = 1'b1;
                if (k >= 0 && k < S - 1) ef[k+1] = 1'b1;
                if (exc) begin
                    evt = 1'b1; tgt = eentry; es = '0; ef = '1;
                end else if (ertn) begin
                    evt = 1'b1; tgt = era; es = '0; ef = '1;
                end else if (br && k < BR) begin
                    evt = 1'b1; tgt = br_tgt;
                    for (int j = 0; j < BR; j++) begin
                        es[j] = 1'b0; ef[j] = 1'b1;
                    end
                end
                if (m_cnt[i] > 0) ef[0] = 1'b1;
            end
            if (model_valid) begin
                check($sformatf("stall_o[dut%0d]", i), 64'(stall_w[i]), 64'(es));
                check($sformatf("flush_o[dut%0d]", i), 64'(flush_w[i]), 64'(ef));
                check($sformatf("redirect_o[dut%0d]", i), 64'(redir_w[i]), 64'(m_redir[i]));
                check($sformatf("new_pc_o[dut%0d]", i), 64'(pc_w[i]), 64'(m_pc[i]));
                check($sformatf("stall_cnt_o[dut%0d]", i), 64'(scnt_w[i]),
                      Perf ? 64'(m_scnt[i]) : 64'd0);
                check($sformatf("redirect_cnt_o[dut%0d]", i), 64'(rcnt_w[i]),
                      Perf ? 64'(m_rcnt[i]) : 64'd0);
            end
            if (rst) begin
                m_cnt[i] = 0; m_redir[i] = 1'b0; m_pc[i] = '0; m_scnt[i] = '0; m_rcnt[i] = '0;
            end else begin
                if (es[0] && m_scnt[i] != 32'hFFFF_FFFF) m_scnt[i] = m_scnt[i] + 1;
                if (m_redir[i] && m_rcnt[i] != 32'hFFFF_FFFF) m_rcnt[i] = m_rcnt[i] + 1;
                if (evt) begin
                    m_cnt[i] = i + 1; m_redir[i] = 1'b1; m_pc[i] = tgt;
                end else begin
                    m_redir[i] = 1'b0;
                    if (m_cnt[i] > 0 && !es[0]) m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
        if (rst) model_valid = 1'b1;
    end

    task automatic idle_inputs();
        stallreq = '0; br = 1'b0; exc = 1'b0; ertn = 1'b0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; br_tgt = '0; eentry = '0; era = '0;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset stall_o", 64'(stall_w[0]), 64'd0);
        check("reset flush_o", 64'(flush_w[0]), 64'd0);
        check("reset redirect_o", 64'(redir_w[0]), 64'd0);
        check("reset new_pc_o", 64'(pc_w[0]), 64'd0);

        // Stall at stage 2
        next_cycle(); rst = 1'b0; stallreq = 5'b00100;
        @(negedge clk);
        check("stall stall_o", 64'(stall_w[0]), 64'h07);
        check("stall flush_o", 64'(flush_w[0]), 64'h08);
        check("stall redirect_o", 64'(redir_w[0]), 64'd0);

        // Branch
        next_cycle(); stallreq = '0; br = 1'b1; br_tgt = 32'h1C00_0040;
        @(negedge clk);
        check("branch T flush_o", 64'(flush_w[0]), 64'h03);
        next_cycle(); br = 1'b0;
        @(negedge clk);
        check("branch T+1 redirect_o", 64'(redir_w[0]), 64'd1);
        check("branch T+1 new_pc_o", 64'(pc_w[0]), 64'h1C00_0040);
        check("branch T+1 flush_o[0]", 64'(flush_w[0][0]), 64'd1);
        next_cycle();
        @(negedge clk);
        check("branch T+2 flush_o[0]", 64'(flush_w[0][0]), 64'd0);

        // Exception beats branch
        next_cycle(); exc = 1'b1; br = 1'b1; eentry = 32'h1C00_8000; br_tgt = 32'h1C00_0999;
        @(negedge clk);
        check("exc T flush_o", 64'(flush_w[0]), 64'h1F);
        check("exc T stall_o", 64'(stall_w[0]), 64'h00);
        next_cycle(); idle_inputs();
        @(negedge clk);
        check("exc T+1 new_pc_o", 64'(pc_w[0]), 64'h1C00_8000);

        // ertn
        next_cycle(); ertn = 1'b1; era = 32'h1C00_0104;
        next_cycle(); idle_inputs();
        @(negedge clk);
        check("ertn T+1 redirect_o", 64'(redir_w[0]), 64'd1);
        check("ertn T+1 new_pc_o", 64'(pc_w[0]), 64'h1C00_0104);
        repeat (4) next_cycle();

        // Blocked branch, then shadow freeze on the FLUSH_CYCLES=2 instance
        next_cycle(); stallreq = 5'b01000; br = 1'b1; br_tgt = 32'h1C00_0300;
        @(negedge clk);
        check("blocked flush_o", 64'(flush_w[1]), 64'h10);
        check("blocked stall_o", 64'(stall_w[1]), 64'h0F);
        next_cycle(); idle_inputs();
        @(negedge clk);
        check("blocked T+1 redirect_o", 64'(redir_w[1]), 64'd0);
        check("blocked T+1 flush_o[0]", 64'(flush_w[1][0]), 64'd0);
        next_cycle(); br = 1'b1; br_tgt = 32'h1C00_0200;
        @(negedge clk);
        check("re-presented flush_o", 64'(flush_w[1]), 64'h03);
        for (int c = 0; c < 3; c++) begin
            next_cycle(); br = 1'b0; stallreq = 5'b00001;
            @(negedge clk);
            check($sformatf("freeze stalled flush_o[0] c%0d", c), 64'(flush_w[1][0]), 64'd1);
        end
        for (int c = 0; c < 2; c++) begin
            next_cycle(); stallreq = '0;
            @(negedge clk);
            check($sformatf("freeze drain flush_o[0] c%0d", c), 64'(flush_w[1][0]), 64'd1);
        end
        next_cycle();
        @(negedge clk);
        check("freeze end flush_o[0]", 64'(flush_w[1][0]), 64'd0);

        // Counters: 4 stall cycles plus one branch from a fresh reset
        next_cycle(); rst = 1'b1;
        next_cycle();
        next_cycle(); rst = 1'b0; stallreq = 5'b00010;
        repeat (3) next_cycle();
        next_cycle(); stallreq = '0; br = 1'b1; br_tgt = 32'h1C00_0500;
        next_cycle(); br = 1'b0;
        next_cycle();
        @(negedge clk);
        check("stall_cnt_o", 64'(scnt_w[0]), Perf ? 64'd4 : 64'd0);
        check("redirect_cnt_o", 64'(rcnt_w[0]), Perf ? 64'd1 : 64'd0);

        // Reset in SHADOW
        next_cycle(); br = 1'b1; br_tgt = 32'h1C00_0600;
        next_cycle(); br = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst-cycle redirect_o", 64'(redir_w[1]), 64'd1);
        check("rst-cycle flush_o", 64'(flush_w[1]), 64'd0);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("post-rst redirect_o", 64'(redir_w[1]), 64'd0);
        check("post-rst flush_o", 64'(flush_w[1]), 64'd0);
        check("post-rst stall_o", 64'(stall_w[1]), 64'd0);
        check("post-rst new_pc_o", 64'(pc_w[1]), 64'd0);
        check("post-rst redirect_cnt_o", 64'(rcnt_w[1]), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst = ($urandom_range(99) == 0);
            for (int j = 0; j < S; j++) stallreq[j] = ($urandom_range(5) == 0);
            br     = ($urandom_range(3) == 0);
            exc    = ($urandom_range(15) == 0);
            ertn   = ($urandom_range(15) == 0);
            br_tgt = $urandom;
            eentry = $urandom;
            era    = $urandom;
        end
        next_cycle(); idle_inputs(); rst = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
